scratch_mem_arbiter: RTL and testbench
======================================

Name: scratch_mem_arbiter

Overview:
- Shares one Scratch_Memory_Controller port set (11-bit read address, 11-bit write address, 32-bit write data, write enable) between N requester FSMs, e.g. Get_wegt, Lsp_expand and the loader.
- Grants are round-robin with lock semantics: a requester keeps the memory until it drops its request.
- A test-override input bypasses arbitration so the bench or test harness can drive the memory directly.
- Sits between the per-function FSMs and the scratch memory inside each pipe wrapper.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 11, memory address width.
- DW, 32, memory data width.
- MAX_HOLD, 1023, max grant cycles before the timeout flag sets; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request; held high for the whole transaction.
- reqReadAddr  input  NREQ*AW  packed read addresses; requester i at bits [i*AW +: AW].
- reqWriteAddr  input  NREQ*AW  packed write addresses.
- reqWriteData  input  NREQ*DW  packed write data.
- reqWriteEn  input  NREQ  per-requester write enable.
- testOverride  input  1  1 = test port owns memory.
- testReadAddr  input  AW  test read address.
- testWriteAddr  input  AW  test write address.
- testWriteData  input  DW  test write data.
- testWriteEn  input  1  test write enable.
- grant  output  NREQ  one-hot registered grant.
- memReadAddr  output  AW  to memory addrb.
- memWriteAddr  output  AW  to memory addra.
- memWriteData  output  DW  to memory dina.
- memWriteEn  output  1  to memory wea.
- busy  output  1  1 while any requester holds the grant.
- timeout  output  1  sticky: a grant exceeded MAX_HOLD cycles.

Behaviour:
- Reset (reset=0, async):
  - grant=0, busy=0, timeout=0, state=IDLE, round-robin pointer=0, hold counter=0.
  - Memory outputs are combinational and read 0 with memWriteEn=0 while no grant is held and testOverride=0.
- States: IDLE, OWNED, HANDOFF.
- IDLE:
  - If any req bit is set, select the first requester at or after the pointer, wrapping modulo NREQ.
  - Registered grant: req seen at edge t gives grant one-hot at t+1; state goes to OWNED.
- OWNED:
  - Muxes route the granted requester's addresses, data and we to the memory, combinationally.
  - The hold counter increments each cycle.
  - If req[owner] is low at an edge: grant clears, pointer = owner+1 (mod NREQ), state goes to HANDOFF.
  - Requests from other requesters are ignored; there is no preemption.
- HANDOFF:
  - One dead cycle with memWriteEn=0, so the owner's last write and read complete.
  - Then go to IDLE and arbitrate in the same cycle: release at t, next grant earliest at t+2.
- memWriteEn = reqWriteEn[owner] only in OWNED; it is 0 in IDLE and HANDOFF.
- A requester's writes with no grant are dropped.
- busy = (state==OWNED).
- Timeout:
  - If MAX_HOLD != 0 and the hold counter reaches MAX_HOLD in OWNED, timeout sets and stays set until reset.
  - The grant is not revoked.
  - The counter saturates and clears on leaving OWNED.
- testOverride=1:
  - Memory outputs come from the test* inputs combinationally, regardless of state.
  - The FSM freezes: no new grants, state held, counter held.
  - The grant output keeps its value, but the owner's we is blocked.
  - When testOverride drops, the frozen state resumes.
- Simultaneous requests in IDLE: the lowest index at or after the pointer wins.
- Release and a new request in the same cycle: the new request is served after HANDOFF.
- Requester deasserts req in the same cycle the grant rises: the owner enters OWNED, sees req low at the next edge and releases. This gives a minimum 1-cycle grant.
- Mid-operation reset: everything returns to reset values immediately; no write issues during reset.
- Read data is not muxed: the memory doutb fans out to all requesters, who qualify it by their own grant.

Test Plan:
- Single request: req=3'b001 at edge 1 -> grant=001 at edge 2, memWriteAddr=reqWriteAddr[0]. Drop req at edge 5 -> grant=0 at edge 6, HANDOFF, busy=0.
- Round-robin: req=3'b111 held, each owner releases after 2 cycles and re-requests -> grant sequence 001,010,100,001, with a dead cycle between each.
- Lock: req[0] owned, req[2] raised -> grant stays 001 until req[0] drops; grant=100 two edges after the release.
- Write gating: requester 1 drives we=1 with addr 0x123 without a grant -> memWriteEn stays 0. Once granted, memWriteEn=1 and memWriteAddr=0x123.
- Override: testOverride=1 during OWNED with testWriteAddr=0x7FF, testWriteEn=1 -> memWriteAddr=0x7FF, memWriteEn=1, grant unchanged. Release override -> owner's routing returns the next cycle.
- Timeout and reset: MAX_HOLD=4, hold req[1] for 6 cycles -> timeout=1 after the 4th owned cycle. Async reset low mid-grant -> grant=0 and timeout=0 before the next clk edge.

Source files
------------

// File: rtl/scratch_mem_arbiter_if.sv
// Bundle of requester, test-port and memory-side signals for the scratch memory arbiter.
// The arbiter uses the slave modport; the requester/test side uses the master modport.
interface scratch_mem_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 11,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] reqReadAddr;
  logic [NREQ*AW-1:0] reqWriteAddr;
  logic [NREQ*DW-1:0] reqWriteData;
  logic [NREQ-1:0]    reqWriteEn;
  logic               testOverride;
  logic [AW-1:0]      testReadAddr;
  logic [AW-1:0]      testWriteAddr;
  logic [DW-1:0]      testWriteData;
  logic               testWriteEn;
  logic [NREQ-1:0]    grant;
  logic [AW-1:0]      memReadAddr;
  logic [AW-1:0]      memWriteAddr;
  logic [DW-1:0]      memWriteData;
  logic               memWriteEn;
  logic               busy;
  logic               timeout;

  modport slave (
    input  req, reqReadAddr, reqWriteAddr, reqWriteData, reqWriteEn,
    input  testOverride, testReadAddr, testWriteAddr, testWriteData, testWriteEn,
    output grant, memReadAddr, memWriteAddr, memWriteData, memWriteEn, busy, timeout
  );

  modport master (
    output req, reqReadAddr, reqWriteAddr, reqWriteData, reqWriteEn,
    output testOverride, testReadAddr, testWriteAddr, testWriteData, testWriteEn,
    input  grant, memReadAddr, memWriteAddr, memWriteData, memWriteEn, busy, timeout
  );
endinterface

// File: rtl/scratch_mem_arbiter.sv
// Round-robin, locking arbiter sharing one scratch memory port between NREQ requester FSMs,
// with a test override that bypasses arbitration and freezes the FSM.
//
// state   | meaning
// IDLE    | no owner; arbitrate each cycle from the round-robin pointer
// OWNED   | owner_q holds the memory until its req drops
// HANDOFF | one dead cycle after release; arbitrates for the next owner
module scratch_mem_arbiter #(
  parameter int NREQ     = 3,
  parameter int AW       = 11,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 1023
) (
  input logic                clk,
  input logic                reset,
  scratch_mem_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HW{1'b1}} : HW'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    HANDOFF = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            timeout_q, timeout_d;

  logic            found;
  logic [IW-1:0]   pick;
  logic            owner_req;
  logic [IW-1:0]   owner_next;

  logic [AW-1:0]   mem_read_addr;
  logic [AW-1:0]   mem_write_addr;
  logic [DW-1:0]   mem_write_data;
  logic            mem_write_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // First requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        pick  = IW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign owner_req  = bus.req[owner_q];
  assign owner_next = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = timeout_q;
    if (!bus.testOverride) begin
      case (state_q)
        // HANDOFF is the dead cycle itself, so it arbitrates exactly like IDLE.
        IDLE, HANDOFF: begin
          hold_cnt_d = '0;
          grant_d    = '0;
          if (found) begin
            state_d       = OWNED;
            owner_d       = pick;
            grant_d[pick] = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        OWNED: begin
          if (!owner_req) begin
            state_d    = HANDOFF;
            grant_d    = '0;
            ptr_d      = owner_next;
            hold_cnt_d = '0;
          end else begin
            if (hold_cnt_q != HOLD_SAT) hold_cnt_d = hold_cnt_q + 1'b1;
            if ((MAX_HOLD != 0) && (hold_cnt_d == HOLD_SAT)) timeout_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          grant_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    mem_read_addr  = '0;
    mem_write_addr = '0;
    mem_write_data = '0;
    mem_write_en   = 1'b0;
    if (bus.testOverride) begin
      mem_read_addr  = bus.testReadAddr;
      mem_write_addr = bus.testWriteAddr;
      mem_write_data = bus.testWriteData;
      mem_write_en   = bus.testWriteEn;
    end else if (state_q == OWNED) begin
      mem_read_addr  = bus.reqReadAddr[owner_q*AW +: AW];
      mem_write_addr = bus.reqWriteAddr[owner_q*AW +: AW];
      mem_write_data = bus.reqWriteData[owner_q*DW +: DW];
      mem_write_en   = bus.reqWriteEn[owner_q];
    end
  end

  assign bus.memReadAddr  = mem_read_addr;
  assign bus.memWriteAddr = mem_write_addr;
  assign bus.memWriteData = mem_write_data;
  assign bus.memWriteEn   = mem_write_en;
  assign bus.grant        = grant_q;
  assign bus.busy         = (state_q == OWNED);
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// Directed bench for scratch_mem_arbiter: reset, grant latency, round-robin order, lock,
// write gating, test override, pointer wrap, minimum grant, timeout and async reset.
module tb_scratch_mem_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 11;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  scratch_mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  scratch_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic set_rq(input int i, input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic we);
    bus.reqReadAddr[i*AW +: AW]  = ra;
    bus.reqWriteAddr[i*AW +: AW] = wa;
    bus.reqWriteData[i*DW +: DW] = wd;
    bus.reqWriteEn[i]            = we;
  endtask

  task automatic test_reset;
    bus.req = 3'b111;
    set_rq(0, 11'h101, 11'h102, 32'h1111_1111, 1'b1);
    set_rq(1, 11'h201, 11'h202, 32'h2222_2222, 1'b1);
    set_rq(2, 11'h301, 11'h302, 32'h3333_3333, 1'b1);
    tick; tick;
    vectors++; if (bus.grant !== 3'b000) begin miscompares++; $display("FAIL reset_grant got=%b exp=%b", bus.grant, 3'b000); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got=%b exp=0", bus.timeout); end
    vectors++; if (bus.memWriteEn !== 1'b0) begin miscompares++; $display("FAIL reset_we got=%b exp=0", bus.memWriteEn); end
    vectors++; if (bus.memWriteAddr !== 11'h000) begin miscompares++; $display("FAIL reset_waddr got=%h exp=000", bus.memWriteAddr); end
    vectors++; if (bus.memWriteData !== 32'h0) begin miscompares++; $display("FAIL reset_wdata got=%h exp=0", bus.memWriteData); end
    bus.req = 3'b000;
    #2;
    reset = 1'b1;
    tick;
  endtask

  task automatic test_single;
    set_rq(0, 11'h011, 11'h022, 32'hA5A5_0001, 1'b1);
    bus.req = 3'b001;
    tick;
    vectors++; if (bus.grant !== 3'b001) begin miscompares++; $display("FAIL single_grant got=%b exp=%b", bus.grant, 3'b001); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    vectors++; if (bus.memWriteAddr !== 11'h022) begin miscompares++; $display("FAIL single_waddr got=%h exp=022", bus.memWriteAddr); end
    vectors++; if (bus.memReadAddr !== 11'h011) begin miscompares++; $display("FAIL single_raddr got=%h exp=011", bus.memReadAddr); end
    vectors++; if (bus.memWriteData !== 32'hA5A5_0001) begin miscompares++; $display("FAIL single_wdata got=%h exp=a5a50001", bus.memWriteData); end
    vectors++; if (bus.memWriteEn !== 1'b1) begin miscompares++; $display("FAIL single_we got=%b exp=1", bus.memWriteEn); end
    tick; tick;
    vectors++; if (bus.grant !== 3'b001) begin miscompares++; $display("FAIL single_hold got=%b exp=%b", bus.grant, 3'b001); end
    bus.req = 3'b000;
    tick;
    vectors++; if (bus.grant !== 3'b000) begin miscompares++; $display("FAIL single_release got=%b exp=%b", bus.grant, 3'b000); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL single_handoff_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.memWriteEn !== 1'b0) begin miscompares++; $display("FAIL single_handoff_we got=%b exp=0", bus.memWriteEn); end
    tick;
  endtask

  task automatic test_write_gating;
    set_rq(1, 11'h055, 11'h123, 32'hDEAD_BEEF, 1'b1);
    bus.req = 3'b000;
    #1;
    vectors++; if (bus.memWriteEn !== 1'b0) begin miscompares++; $display("FAIL gate_nogrant_we got=%b exp=0", bus.memWriteEn); end
    tick;
    vectors++; if (bus.memWriteEn !== 1'b0) begin miscompares++; $display("FAIL gate_nogrant_we2 got=%b exp=0", bus.memWriteEn); end
    bus.req = 3'b010;
    tick;
    vectors++; if (bus.grant !== 3'b010) begin miscompares++; $display("FAIL gate_grant got=%b exp=%b", bus.grant, 3'b010); end
    vectors++; if (bus.memWriteEn !== 1'b1) begin miscompares++; $display("FAIL gate_we got=%b exp=1", bus.memWriteEn); end
    vectors++; if (bus.memWriteAddr !== 11'h123) begin miscompares++; $display("FAIL gate_waddr got=%h exp=123", bus.memWriteAddr); end
    vectors++; if (bus.memWriteData !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL gate_wdata got=%h exp=deadbeef", bus.memWriteData); end
    bus.req = 3'b000;
    tick;
    vectors++; if (bus.memWriteEn !== 1'b0) begin miscompares++; $display("FAIL gate_handoff_we got=%b exp=0", bus.memWriteEn); end
    tick;
  endtask

  task automatic test_round_robin;
    logic [NREQ-1:0] exp_seq [4];
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
    do_reset;
    bus.req = 3'b111;
    tick;
    for (int s = 0; s < 4; s++) begin
      vectors++; if (bus.grant !== exp_seq[s]) begin miscompares++; $display("FAIL rr_grant[%0d] got=%b exp=%b", s, bus.grant, exp_seq[s]); end
      tick;
      bus.req = 3'b111 & ~exp_seq[s];
      tick;
      vectors++; if (bus.grant !== 3'b000) begin miscompares++; $display("FAIL rr_dead[%0d] got=%b exp=%b", s, bus.grant, 3'b000); end
      bus.req = 3'b111;
      tick;
    end
    bus.req = 3'b000;
    tick; tick;
  endtask

  task automatic test_lock;
    do_reset;
    bus.req = 3'b001;
    tick;
    vectors++; if (bus.grant !== 3'b001) begin miscompares++; $display("FAIL lock_first got=%b exp=%b", bus.grant, 3'b001); end
    bus.req = 3'b101;
    tick;
    vectors++; if (bus.grant !== 3'b001) begin miscompares++; $display("FAIL lock_hold1 got=%b exp=%b", bus.grant, 3'b001); end
    tick;
    vectors++; if (bus.grant !== 3'b001) begin miscompares++; $display("FAIL lock_hold2 got=%b exp=%b", bus.grant, 3'b001); end
    bus.req = 3'b100;
    tick;
    vectors++; if (bus.grant !== 3'b000) begin miscompares++; $display("FAIL lock_release got=%b exp=%b", bus.grant, 3'b000); end
    tick;
    vectors++; if (bus.grant !== 3'b100) begin miscompares++; $display("FAIL lock_next got=%b exp=%b", bus.grant, 3'b100); end
    bus.req = 3'b000;
    tick; tick;
  endtask

  task automatic test_wrap;
    // pointer has wrapped to 0 after requester 2 released
    bus.req = 3'b110;
    tick;
    vectors++; if (bus.grant !== 3'b010) begin miscompares++; $display("FAIL wrap_simul got=%b exp=%b", bus.grant, 3'b010); end
    bus.req = 3'b000;
    tick; tick;
    bus.req = 3'b011;
    tick;
    vectors++; if (bus.grant !== 3'b001) begin miscompares++; $display("FAIL wrap_mod got=%b exp=%b", bus.grant, 3'b001); end
    bus.req = 3'b000;
    tick; tick;
  endtask

  task automatic test_min_grant;
    bus.req = 3'b001;
    tick;
    vectors++; if (bus.grant !== 3'b001) begin miscompares++; $display("FAIL min_grant got=%b exp=%b", bus.grant, 3'b001); end
    bus.req = 3'b000;
    tick;
    vectors++; if (bus.grant !== 3'b000) begin miscompares++; $display("FAIL min_release got=%b exp=%b", bus.grant, 3'b000); end
    tick;
  endtask

  task automatic test_override;
    do_reset;
    set_rq(2, 11'h0AA, 11'h0BB, 32'h1234_5678, 1'b1);
    bus.req = 3'b100;
    tick;
    vectors++; if (bus.memWriteAddr !== 11'h0BB) begin miscompares++; $display("FAIL ovr_pre_waddr got=%h exp=0bb", bus.memWriteAddr); end
    bus.testOverride  = 1'b1;
    bus.testReadAddr  = 11'h3C3;
    bus.testWriteAddr = 11'h7FF;
    bus.testWriteData = 32'hCAFE_F00D;
    bus.testWriteEn   = 1'b1;
    #1;
    vectors++; if (bus.memWriteAddr !== 11'h7FF) begin miscompares++; $display("FAIL ovr_waddr got=%h exp=7ff", bus.memWriteAddr); end
    vectors++; if (bus.memReadAddr !== 11'h3C3) begin miscompares++; $display("FAIL ovr_raddr got=%h exp=3c3", bus.memReadAddr); end
    vectors++; if (bus.memWriteData !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL ovr_wdata got=%h exp=cafef00d", bus.memWriteData); end
    vectors++; if (bus.memWriteEn !== 1'b1) begin miscompares++; $display("FAIL ovr_we got=%b exp=1", bus.memWriteEn); end
    tick; tick;
    vectors++; if (bus.grant !== 3'b100) begin miscompares++; $display("FAIL ovr_grant got=%b exp=%b", bus.grant, 3'b100); end
    bus.req = 3'b000;
    tick; tick;
    vectors++; if (bus.grant !== 3'b100) begin miscompares++; $display("FAIL ovr_frozen got=%b exp=%b", bus.grant, 3'b100); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL ovr_busy got=%b exp=1", bus.busy); end
    bus.testWriteEn = 1'b0;
    #1;
    vectors++; if (bus.memWriteEn !== 1'b0) begin miscompares++; $display("FAIL ovr_owner_we_blocked got=%b exp=0", bus.memWriteEn); end
    bus.req = 3'b100;
    bus.testOverride = 1'b0;
    #1;
    vectors++; if (bus.memWriteAddr !== 11'h0BB) begin miscompares++; $display("FAIL ovr_resume_waddr got=%h exp=0bb", bus.memWriteAddr); end
    tick;
    vectors++; if (bus.memWriteEn !== 1'b1) begin miscompares++; $display("FAIL ovr_resume_we got=%b exp=1", bus.memWriteEn); end
    vectors++; if (bus.timeout !== 1'b0) begin miscompares++; $display("FAIL ovr_counter_frozen timeout got=%b exp=0", bus.timeout); end
    bus.req = 3'b000;
    tick; tick;
  endtask

  task automatic test_timeout;
    logic exp_to;
    do_reset;
    set_rq(1, 11'h044, 11'h045, 32'h0000_0046, 1'b1);
    bus.req = 3'b010;
    tick;
    for (int c = 1; c <= 6; c++) begin
      tick;
      exp_to = (c >= 4);
      vectors++; if (bus.timeout !== exp_to) begin miscompares++; $display("FAIL timeout_cyc%0d got=%b exp=%b", c, bus.timeout, exp_to); end
      vectors++; if (bus.grant !== 3'b010) begin miscompares++; $display("FAIL timeout_grant_cyc%0d got=%b exp=%b", c, bus.grant, 3'b010); end
    end
    #3;
    reset = 1'b0;
    #1;
    vectors++; if (bus.grant !== 3'b000) begin miscompares++; $display("FAIL async_grant got=%b exp=%b", bus.grant, 3'b000); end
    vectors++; if (bus.timeout !== 1'b0) begin miscompares++; $display("FAIL async_timeout got=%b exp=0", bus.timeout); end
    vectors++; if (bus.memWriteEn !== 1'b0) begin miscompares++; $display("FAIL async_we got=%b exp=0", bus.memWriteEn); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL async_busy got=%b exp=0", bus.busy); end
    bus.req = 3'b000;
    #2;
    reset = 1'b1;
    tick;
  endtask

  initial begin
    bus.req = '0;
    bus.reqReadAddr = '0;
    bus.reqWriteAddr = '0;
    bus.reqWriteData = '0;
    bus.reqWriteEn = '0;
    bus.testOverride = 1'b0;
    bus.testReadAddr = '0;
    bus.testWriteAddr = '0;
    bus.testWriteData = '0;
    bus.testWriteEn = 1'b0;
    test_reset;
    test_single;
    test_write_gating;
    test_round_robin;
    test_lock;
    test_wrap;
    test_min_grant;
    test_override;
    test_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
